// File: rtl/cam_pkg.sv
// Shared constants and types for the CAM command initiator and its helpers.
package cam_pkg;

  localparam int CAM_WIDTH = 32;
  localparam int CAM_DEPTH = 32;
  localparam int CAM_IDX_W = $clog2(CAM_DEPTH);

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_SEARCH = 2'b10,
    OP_INSERT = 2'b11
  } cam_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SWAIT,
    ST_INS_WR,
    ST_RESP
  } cam_init_state_e;

  typedef struct packed {
    logic                 hit;
    logic                 err;
    logic [CAM_IDX_W-1:0] index;
    logic [CAM_WIDTH-1:0] data;
  } cam_rsp_t;

endpackage

// File: rtl/cam_victim_ptr.sv
// Round-robin victim row pointer for INSERT misses; wraps from DEPTH-1 back to 0.
module cam_victim_ptr #(
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             inc,
  output logic [IDX_W-1:0] ptr_o
);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (inc) begin
      ptr_o <= (ptr_o == IDX_W'(DEPTH - 1)) ? '0 : ptr_o + IDX_W'(1);
    end
  end

endmodule

// File: rtl/cam_initiator.sv
// Command-side master for the CAM: runs one WRITE/READ/SEARCH/INSERT at a time over registered
// CAM port signals and returns a single registered response over a valid/ready port.
module cam_initiator
  import cam_pkg::*;
#(
  parameter int DEPTH      = CAM_DEPTH,
  parameter int SEARCH_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [CAM_IDX_W-1:0] cmd_index_i,
  input  logic [CAM_WIDTH-1:0] cmd_data_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic                 rsp_err_o,
  output logic [CAM_IDX_W-1:0] rsp_index_o,
  output logic [CAM_WIDTH-1:0] rsp_data_o,
  output logic                 cam_write_enable_o,
  output logic [CAM_IDX_W-1:0] cam_write_index_o,
  output logic [CAM_WIDTH-1:0] cam_write_data_o,
  output logic [CAM_IDX_W-1:0] cam_read_index_o,
  input  logic [CAM_WIDTH-1:0] cam_read_value_i,
  input  logic                 cam_read_valid_i,
  output logic                 cam_search_enable_o,
  output logic [CAM_WIDTH-1:0] cam_search_data_o,
  input  logic [CAM_IDX_W-1:0] cam_search_index_i,
  input  logic                 cam_search_valid_i
);

  localparam logic [7:0] LAT_LAST = 8'(SEARCH_LAT);

  cam_init_state_e      state;
  cam_op_e              op_q;
  logic [CAM_IDX_W-1:0] index_q;
  logic [CAM_WIDTH-1:0] data_q;
  logic                 oob_q;
  logic [7:0]           lat_cnt;
  cam_rsp_t             rsp_q;
  logic [CAM_IDX_W-1:0] victim_ptr;
  logic                 victim_inc;
  logic                 cmd_oob;

  assign cmd_oob    = int'(cmd_index_i) >= DEPTH;
  assign victim_inc = (state == ST_INS_WR);

  assign rsp_hit_o   = rsp_q.hit;
  assign rsp_err_o   = rsp_q.err;
  assign rsp_index_o = rsp_q.index;
  assign rsp_data_o  = rsp_q.data;

  cam_victim_ptr #(
    .DEPTH(DEPTH),
    .IDX_W(CAM_IDX_W)
  ) u_victim_ptr (
    .clk  (clk),
    .rst_i(rst_i),
    .inc  (victim_inc),
    .ptr_o(victim_ptr)
  );

  // CAM strobes are set up on the accept edge so they are already registered in EXEC;
  // out-of-range WRITE/READ skip the strobe and only report err from EXEC.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state               <= ST_IDLE;
      op_q                <= OP_WRITE;
      index_q             <= '0;
      data_q              <= '0;
      oob_q               <= 1'b0;
      lat_cnt             <= '0;
      rsp_q               <= '0;
      cmd_ready_o         <= 1'b1;
      rsp_valid_o         <= 1'b0;
      cam_write_enable_o  <= 1'b0;
      cam_write_index_o   <= '0;
      cam_write_data_o    <= '0;
      cam_read_index_o    <= '0;
      cam_search_enable_o <= 1'b0;
      cam_search_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid_i) begin
            op_q        <= cam_op_e'(cmd_op_i);
            index_q     <= cmd_index_i;
            data_q      <= cmd_data_i;
            oob_q       <= cmd_oob;
            lat_cnt     <= '0;
            cmd_ready_o <= 1'b0;
            state       <= ST_EXEC;
            case (cam_op_e'(cmd_op_i))
              OP_WRITE: begin
                if (!cmd_oob) begin
                  cam_write_enable_o <= 1'b1;
                  cam_write_index_o  <= cmd_index_i;
                  cam_write_data_o   <= cmd_data_i;
                end
              end
              OP_READ: begin
                if (!cmd_oob) cam_read_index_o <= cmd_index_i;
              end
              default: begin
                cam_search_enable_o <= 1'b1;
                cam_search_data_o   <= cmd_data_i;
              end
            endcase
          end
        end
        ST_EXEC, ST_SWAIT: begin
          cam_write_enable_o <= 1'b0;
          if (op_q == OP_WRITE || op_q == OP_READ) begin
            rsp_q.hit   <= (op_q == OP_READ) && !oob_q && cam_read_valid_i;
            rsp_q.err   <= oob_q;
            rsp_q.index <= index_q;
            rsp_q.data  <= (op_q == OP_READ && !oob_q) ? cam_read_value_i : data_q;
            rsp_valid_o <= 1'b1;
            state       <= ST_RESP;
          end else if (lat_cnt == LAT_LAST) begin
            cam_search_enable_o <= 1'b0;
            rsp_q.err           <= 1'b0;
            rsp_q.data          <= data_q;
            if (op_q == OP_SEARCH || cam_search_valid_i) begin
              rsp_q.hit   <= cam_search_valid_i;
              rsp_q.index <= cam_search_index_i;
              rsp_valid_o <= 1'b1;
              state       <= ST_RESP;
            end else begin
              // INSERT miss: the write strobe rises on the same edge the search strobe drops
              cam_write_enable_o <= 1'b1;
              cam_write_index_o  <= victim_ptr;
              cam_write_data_o   <= data_q;
              rsp_q.hit          <= 1'b0;
              rsp_q.index        <= victim_ptr;
              state              <= ST_INS_WR;
            end
          end else begin
            lat_cnt <= lat_cnt + 8'd1;
            state   <= ST_SWAIT;
          end
        end
        ST_INS_WR: begin
          cam_write_enable_o <= 1'b0;
          rsp_valid_o        <= 1'b1;
          state              <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_initiator.sv
// Directed scoreboard bench: a behavioural CAM behind the default instance, plus a DEPTH=20
// instance with tied-off CAM inputs for out-of-range and reset-abort checks.
module tb_cam_initiator;
  import cam_pkg::*;

  typedef struct {
    string       name;
    logic        hit;
    logic        err;
    logic [4:0]  index;
    logic [31:0] data;
    int          n_wr;
    int          n_srch;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_index;
  logic [31:0] cmd_data;
  logic        rsp_ready;

  logic        cmd_valid, cmd_ready, rsp_valid, rsp_hit, rsp_err;
  logic [4:0]  rsp_index;
  logic [31:0] rsp_data;
  logic        cam_we, cam_se, cam_rvalid, m_sv;
  logic [4:0]  cam_widx, cam_ridx, m_sidx;
  logic [31:0] cam_wdata, cam_rvalue, cam_sdata;

  logic        cmd_valid20, cmd_ready20, rsp_valid20, rsp_hit20, rsp_err20;
  logic [4:0]  rsp_index20, cam_widx20, cam_ridx20;
  logic [31:0] rsp_data20, cam_wdata20, cam_sdata20;
  logic        cam_we20, cam_se20;

  logic [31:0] cam_mem [32];
  logic [31:0] cam_vld;

  exp_t sb_q[$];
  exp_t sb20_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_cnt[2];
  int   srch_cnt[2];

  cam_initiator #(.DEPTH(32), .SEARCH_LAT(1)) dut (
    .clk(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit),
    .rsp_err_o(rsp_err), .rsp_index_o(rsp_index), .rsp_data_o(rsp_data),
    .cam_write_enable_o(cam_we), .cam_write_index_o(cam_widx), .cam_write_data_o(cam_wdata),
    .cam_read_index_o(cam_ridx), .cam_read_value_i(cam_rvalue), .cam_read_valid_i(cam_rvalid),
    .cam_search_enable_o(cam_se), .cam_search_data_o(cam_sdata),
    .cam_search_index_i(m_sidx), .cam_search_valid_i(m_sv)
  );

  cam_initiator #(.DEPTH(20), .SEARCH_LAT(1)) dut20 (
    .clk(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid20), .cmd_ready_o(cmd_ready20), .cmd_op_i(cmd_op),
    .cmd_index_i(cmd_index), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid20), .rsp_ready_i(rsp_ready), .rsp_hit_o(rsp_hit20),
    .rsp_err_o(rsp_err20), .rsp_index_o(rsp_index20), .rsp_data_o(rsp_data20),
    .cam_write_enable_o(cam_we20), .cam_write_index_o(cam_widx20), .cam_write_data_o(cam_wdata20),
    .cam_read_index_o(cam_ridx20), .cam_read_value_i(32'hFFFF_FFFF), .cam_read_valid_i(1'b1),
    .cam_search_enable_o(cam_se20), .cam_search_data_o(cam_sdata20),
    .cam_search_index_i(5'd9), .cam_search_valid_i(1'b0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural CAM: registered search result, lowest matching row wins
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cam_mem[i] <= '0;
      cam_vld <= '0;
      m_sv    <= 1'b0;
      m_sidx  <= '0;
    end else begin
      if (cam_we) begin
        cam_mem[cam_widx] <= cam_wdata;
        cam_vld[cam_widx] <= 1'b1;
      end
      if (cam_se) begin
        m_sv   <= 1'b0;
        m_sidx <= '0;
        for (int i = 31; i >= 0; i--)
          if (cam_vld[i] && cam_mem[i] == cam_sdata) begin
            m_sv   <= 1'b1;
            m_sidx <= 5'(i);
          end
      end
    end
  end

  assign cam_rvalue = cam_mem[cam_ridx];
  assign cam_rvalid = cam_vld[cam_ridx];

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic reportTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected one", name);
  endtask

  task automatic monStep(input bit sel, input logic we, input logic se, input logic valid,
                         input logic hit, input logic err, input logic [4:0] idx, input logic [31:0] data);
    exp_t e;
    int   k;
    k = sel ? 1 : 0;
    if (we && se) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL enable_overlap[%0d]: got write and search both 1, expected at most one", k);
    end
    if (we) wr_cnt[k]++;
    if (se) srch_cnt[k]++;
    if (valid && rsp_ready) begin
      if ((sel ? sb20_q.size() : sb_q.size()) == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_rsp[%0d]: got a response, expected none", k);
      end else begin
        if (sel) e = sb20_q.pop_front();
        else     e = sb_q.pop_front();
        checkOutput({e.name, ".hit"},    32'(hit),         32'(e.hit));
        checkOutput({e.name, ".err"},    32'(err),         32'(e.err));
        checkOutput({e.name, ".index"},  32'(idx),         32'(e.index));
        checkOutput({e.name, ".data"},   data,             e.data);
        checkOutput({e.name, ".n_wr"},   32'(wr_cnt[k]),   32'(e.n_wr));
        checkOutput({e.name, ".n_srch"}, 32'(srch_cnt[k]), 32'(e.n_srch));
      end
      wr_cnt[k]   = 0;
      srch_cnt[k] = 0;
    end
  endtask

  // Monitor: strobe counts since the last response are part of every scoreboard entry
  initial begin
    wr_cnt   = '{0, 0};
    srch_cnt = '{0, 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        wr_cnt   = '{0, 0};
        srch_cnt = '{0, 0};
      end else begin
        monStep(1'b0, cam_we, cam_se, rsp_valid, rsp_hit, rsp_err, rsp_index, rsp_data);
        monStep(1'b1, cam_we20, cam_se20, rsp_valid20, rsp_hit20, rsp_err20, rsp_index20, rsp_data20);
      end
    end
  end

  task automatic issueCmd(input bit sel, input logic [1:0] op, input logic [4:0] idx, input logic [31:0] data);
    int t = 0;
    while (!(sel ? cmd_ready20 : cmd_ready) && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 50) reportTimeout("cmd_ready");
    cmd_op    = op;
    cmd_index = idx;
    cmd_data  = data;
    if (sel) cmd_valid20 = 1'b1;
    else     cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_valid20 = 1'b0;
  endtask

  task automatic waitDrained(input bit sel);
    int t = 0;
    while ((sel ? sb20_q.size() : sb_q.size()) != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) begin
      reportTimeout("response");
      if (sel) sb20_q.delete();
      else     sb_q.delete();
    end
  endtask

  task automatic applyStimulus(input bit sel, input string name, input logic [1:0] op,
                               input logic [4:0] idx, input logic [31:0] data,
                               input logic ehit, input logic eerr, input logic [4:0] eidx,
                               input logic [31:0] edata, input int nw, input int ns);
    exp_t e;
    e = '{name: name, hit: ehit, err: eerr, index: eidx, data: edata, n_wr: nw, n_srch: ns};
    if (sel) sb20_q.push_back(e);
    else     sb_q.push_back(e);
    issueCmd(sel, op, idx, data);
    waitDrained(sel);
  endtask

  initial begin
    int t;
    exp_t e;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_valid20 = 1'b0;
    cmd_op = 2'b00; cmd_index = '0; cmd_data = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset.rsp_hit",   32'(rsp_hit),   32'd0);
    checkOutput("reset.rsp_data",  rsp_data,       32'd0);
    checkOutput("reset.write_en",  32'(cam_we),    32'd0);
    checkOutput("reset.search_en", 32'(cam_se),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(0, "write3",      OP_WRITE,  5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd3, 32'hDEAD_BEEF, 1, 0);
    applyStimulus(0, "read3",       OP_READ,   5'd3, 32'h0,         1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF, 0, 0);
    applyStimulus(0, "search_hit",  OP_SEARCH, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 5'd3, 32'hDEAD_BEEF, 0, 2);
    applyStimulus(0, "search_miss", OP_SEARCH, 5'd0, 32'h0000_1234, 1'b0, 1'b0, 5'd0, 32'h0000_1234, 0, 2);
    applyStimulus(0, "read_empty",  OP_READ,   5'd7, 32'h0,         1'b0, 1'b0, 5'd7, 32'h0,         0, 0);

    // Back-pressure: response held, a stray command offered meanwhile must be ignored
    rsp_ready = 1'b0;
    e = '{name: "stall_write", hit: 1'b0, err: 1'b0, index: 5'd10, data: 32'h5555_AAAA, n_wr: 1, n_srch: 0};
    sb_q.push_back(e);
    issueCmd(0, OP_WRITE, 5'd10, 32'h5555_AAAA);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) reportTimeout("stall.rsp_valid");
    cmd_op = OP_READ; cmd_index = 5'd3; cmd_data = 32'h0; cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall.rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("stall.rsp_index", 32'(rsp_index), 32'd10);
      checkOutput("stall.rsp_data",  rsp_data,       32'h5555_AAAA);
      checkOutput("stall.cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("stall.strobes",   32'({cam_we, cam_se}), 32'd0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    waitDrained(0);

    // Fresh CAM and pointer, then fill every row and wrap once
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 33; i++)
      applyStimulus(0, "insert_fill", OP_INSERT, 5'd0, 32'(32'hA0 + i),
                    1'b0, 1'b0, 5'(i % 32), 32'(32'hA0 + i), 1, 2);
    applyStimulus(0, "insert_dup",  OP_INSERT, 5'd0, 32'hA5, 1'b1, 1'b0, 5'd5, 32'hA5, 0, 2);
    applyStimulus(0, "insert_next", OP_INSERT, 5'd0, 32'h77, 1'b0, 1'b0, 5'd1, 32'h77, 1, 2);
    applyStimulus(0, "search_gone", OP_SEARCH, 5'd0, 32'hA0, 1'b0, 1'b0, 5'd0, 32'hA0, 0, 2);
    applyStimulus(0, "search_wrap", OP_SEARCH, 5'd0, 32'hC0, 1'b1, 1'b0, 5'd0, 32'hC0, 0, 2);

    applyStimulus(1, "oob_read", OP_READ, 5'd25, 32'h42, 1'b0, 1'b1, 5'd25, 32'h42, 0, 0);
    checkOutput("oob_read.read_index", 32'(cam_ridx20), 32'd0);
    applyStimulus(1, "ins20_first", OP_INSERT, 5'd0, 32'h11, 1'b0, 1'b0, 5'd0, 32'h11, 1, 2);

    // Reset while waiting on the search result aborts the INSERT
    issueCmd(1, OP_INSERT, 5'd0, 32'h22);
    @(posedge clk); #1;
    checkOutput("abort.search_en_before", 32'(cam_se20), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort.search_en",  32'(cam_se20),    32'd0);
    checkOutput("abort.write_en",   32'(cam_we20),    32'd0);
    checkOutput("abort.rsp_valid",  32'(rsp_valid20), 32'd0);
    checkOutput("abort.cmd_ready",  32'(cmd_ready20), 32'd1);
    #5;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1, "ins20_after_rst", OP_INSERT, 5'd0, 32'h33, 1'b0, 1'b0, 5'd0, 32'h33, 1, 2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
